// File: rtl/jk_mod_counter_pkg.sv
// Shared defaults for the JK modulo counter and its next-state mode encoding.
// By convention the top derives MAXV = MODULUS-1 as a WIDTH-bit constant.
package jk_mod_counter_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_MODULUS = 10;

    typedef enum logic [1:0] {
        NS_HOLD = 2'd0,
        NS_LOAD = 2'd1,
        NS_UP   = 2'd2,
        NS_DOWN = 2'd3
    } ns_sel_t;

    function automatic ns_sel_t ns_select(input logic load, input logic en, input logic up);
        if (load)
            return NS_LOAD;
        else if (!en)
            return NS_HOLD;
        else if (up)
            return NS_UP;
        else
            return NS_DOWN;
    endfunction

endpackage

// File: rtl/jk_mod_counter_jk_cell.sv
// Single JK flip-flop with asynchronous active-low reset to 0.
module jk_cell
    import jk_mod_counter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= 1'b0;
        else
            q <= (j & ~q) | (~k & q);
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter: toggle-form excitation feeding a bank of JK cells,
// plus combinational terminal count and a registered wrap pulse.
module jk_mod_counter
    import jk_mod_counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic [WIDTH-1:0] j_dbg,
    output logic [WIDTH-1:0] k_dbg
);

    localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS = 2^WIDTH still compares correctly.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    ns_sel_t          sel;
    logic [WIDTH-1:0] nxt;
    logic             illegal;
    logic             din_ok;
    logic             wrap_d;

    assign illegal = ({1'b0, q} >= MOD_EXT);
    assign din_ok  = ({1'b0, din} < MOD_EXT);
    assign sel     = ns_select(load, en, up);

    always_comb begin
        nxt = q;
        case (sel)
            NS_LOAD: nxt = din_ok ? din : '0;
            NS_UP: begin
                if (illegal || q == MAXV)
                    nxt = '0;
                else
                    nxt = q + WIDTH'(1);
            end
            NS_DOWN: begin
                if (illegal)
                    nxt = '0;
                else if (q == '0)
                    nxt = MAXV;
                else
                    nxt = q - WIDTH'(1);
            end
            default: nxt = q;
        endcase
    end

    // Toggle form: any bit that must change gets J=K=1.
    assign j_dbg = q ^ nxt;
    assign k_dbg = q ^ nxt;

    assign tc     = en & (up ? (q == MAXV) : (q == '0));
    assign wrap_d = ~load & en & tc;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j_dbg[i]),
            .k     (k_dbg[i]),
            .q     (q[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wrap <= 1'b0;
        else
            wrap <= wrap_d;
    end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter (WIDTH=4, MODULUS=10); samples on the falling edge.
module tb_jk_mod_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic [3:0] q;
    logic       tc;
    logic       wrap;
    logic [3:0] j_dbg;
    logic [3:0] k_dbg;

    int checks   = 0;
    int failures = 0;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .up    (up),
        .load  (load),
        .din   (din),
        .q     (q),
        .tc    (tc),
        .wrap  (wrap),
        .j_dbg (j_dbg),
        .k_dbg (k_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b1;
        up    = 1'b1;
        load  = 1'b0;
        din   = 4'd0;

        // Reset held with clock running
        repeat (3) step();
        check("rst_q", 32'(q), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        reset = 1'b1;

        // Count up 1..9, with excitation spot checks
        for (int i = 1; i <= 9; i++) begin
            step();
            check("up_q", 32'(q), 32'(i));
            if (i == 7) begin
                check("exc7_j", 32'(j_dbg), 32'hF);
                check("exc7_k", 32'(k_dbg), 32'hF);
            end
            if (i < 9) check("up_tc_lo", 32'(tc), 32'd0);
        end
        check("up_tc9", 32'(tc), 32'd1);
        check("exc9_j", 32'(j_dbg), 32'h9);
        check("exc9_k", 32'(k_dbg), 32'h9);
        check("up_wrap_pre", 32'(wrap), 32'd0);
        step();
        check("upwrap_q", 32'(q), 32'd0);
        check("upwrap_wrap", 32'(wrap), 32'd1);
        step();
        check("after_wrap_q", 32'(q), 32'd1);
        check("after_wrap_wrap", 32'(wrap), 32'd0);

        // Down count through 0 -> 9 -> 8
        up = 1'b0;
        step();
        check("dn_q0", 32'(q), 32'd0);
        check("dn_wrap0", 32'(wrap), 32'd0);
        check("dn_tc0", 32'(tc), 32'd1);
        step();
        check("dn_q9", 32'(q), 32'd9);
        check("dn_wrap9", 32'(wrap), 32'd1);
        check("dn_tc9", 32'(tc), 32'd0);
        step();
        check("dn_q8", 32'(q), 32'd8);
        check("dn_wrap8", 32'(wrap), 32'd0);

        // Load priority
        en = 1'b0; load = 1'b1; din = 4'd3;
        step();
        check("ld3_q", 32'(q), 32'd3);
        en = 1'b1; up = 1'b1; din = 4'd7;
        step();
        check("ld7_q", 32'(q), 32'd7);
        check("ld7_wrap", 32'(wrap), 32'd0);
        din = 4'd12;
        step();
        check("ld12_q", 32'(q), 32'd0);
        check("ld12_wrap", 32'(wrap), 32'd0);

        // Load of MAXV while tc is high must not wrap
        din = 4'd9;
        step();
        check("ld9_q", 32'(q), 32'd9);
        check("ld9_tc", 32'(tc), 32'd1);
        step();
        check("ld9b_q", 32'(q), 32'd9);
        check("ld9b_wrap", 32'(wrap), 32'd0);

        // tc follows en/up combinationally at q=9
        load = 1'b0; en = 1'b0;
        #1 check("tc_en0", 32'(tc), 32'd0);
        en = 1'b1; up = 1'b0;
        #1 check("tc_dn", 32'(tc), 32'd0);
        up = 1'b1;
        #1 check("tc_up", 32'(tc), 32'd1);

        // Async reset mid-count at q=6
        en = 1'b0; load = 1'b1; din = 4'd6;
        step();
        check("ld6_q", 32'(q), 32'd6);
        load = 1'b0; en = 1'b1;
        #2 reset = 1'b0;
        #1 check("async_q", 32'(q), 32'd0);
        check("async_wrap", 32'(wrap), 32'd0);
        step();
        en = 1'b0;
        reset = 1'b1;
        step();
        check("hold_q1", 32'(q), 32'd0);
        step();
        check("hold_q2", 32'(q), 32'd0);
        check("hold_j", 32'(j_dbg), 32'd0);
        check("hold_k", 32'(k_dbg), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jk_mod_counter.md
# jk_mod_counter

Synchronous modulo-N up/down counter whose state bits are JK flip-flops driven by a next-state/excitation stage. The block computes J/K for every bit from the current count and the control inputs, then feeds them into a bank of asynchronous-reset JK cells. It is the upstream excitation stage for the team's JK flip-flop primitive and serves as the reference counter for later sequential drills.

## Interface
- WIDTH, 4, count width in bits.
- MODULUS, 10, count range 0..MODULUS-1; legal range 2..2^WIDTH.
- clk  input  1  rising-edge clock.
- reset  input  1  reset, asynchronous, active-low.
- en  input  1  count enable.
- up  input  1  direction: 1 counts up, 0 counts down.
- load  input  1  synchronous parallel load; has priority over en.
- din  input  WIDTH  load value.
- q  output  WIDTH  current count, taken directly from the JK cell outputs.
- tc  output  1  terminal count, combinational: en & (up ? q==MODULUS-1 : q==0).
- wrap  output  1  registered one-cycle pulse, high in the cycle after the count wraps.
- j_dbg, k_dbg  output  WIDTH each  current excitation vectors, for verification only.

## Operation
- Next-state value nxt:
  - load=1: nxt = din when din < MODULUS, otherwise 0.
  - load=0, en=1, up=1: nxt = (q==MODULUS-1) ? 0 : q+1.
  - load=0, en=1, up=0: nxt = (q==0) ? MODULUS-1 : q-1.
  - load=0, en=0: nxt = q.
- Excitation is toggle form per bit i: j_dbg[i] = k_dbg[i] = q[i] ^ nxt[i].
  - J=K=1 toggles the bit; J=K=0 holds it.
  - The JK cell must realise Q+ = (J & ~Q) | (~K & Q).
- Width rules:
  - Internal arithmetic is WIDTH bits.
  - MODULUS-1 is compared as a WIDTH-bit constant.
  - Natural binary rollover must never produce a value ≥ MODULUS.
- wrap is set to 1 on an edge where load=0, en=1 and tc=1; otherwise it is 0.
- A load never sets wrap, including a load of 0 or of MODULUS-1.
- Illegal state: if q ≥ MODULUS (only reachable through X-propagation or a MODULUS change), the next enabled count goes to 0 in either direction.

## Timing
- Reset (reset=0, asynchronous) forces q=0 and wrap=0 immediately, independent of clk.
  - tc follows combinationally from q.
- Release of reset is synchronous in effect: the first state change occurs on the first rising clk edge with reset=1.
- Latency:
  - load or count takes effect one clk edge after the inputs are sampled.
  - tc is zero-latency from q, en and up.
  - wrap lags the wrapping edge by 0 cycles: it is registered on the same edge that q wraps, so it is visible for the following cycle.
- Simultaneous load and en: load wins; no count, no wrap.
- Direction change mid-count: takes effect on the next edge; no extra latency.
- Reset asserted mid-count or mid-load: the in-flight update is discarded and q=0.
- Changing en or up while tc=1: tc updates combinationally.

## Structure
- Shared include file holds:
  - default WIDTH and MODULUS.
  - a localparam MAXV = MODULUS-1 derivation convention.
- Sub-module jk_cell: one JK flip-flop with asynchronous active-low reset to 0, instantiated WIDTH times via generate.
- Top level holds:
  - the next-state/excitation logic, combinational.
  - the tc logic.
  - the wrap register, same clk/reset as the cells.

## Test plan
- Reset: hold reset=0 with clk running; then release with en=1, up=1.
  - Required: q=0 and wrap=0 while reset is low; counts 1,2,…,9 after release; tc=1 at q=9.
  - Next edge: q=0 and wrap=1 for exactly one cycle.
- Down count: from q=0 with en=1, up=0.
  - Required: q=9, then 8; wrap=1 the cycle after the 0→9 wrap; tc=1 while q=0.
- Load priority: q=3, load=1, en=1, din=7.
  - Required: q=7 next edge, no increment, wrap=0.
  - With din=12 (out of range): q=0, wrap=0.
- Excitation check: at q=0111 counting up.
  - Required: j_dbg = k_dbg = 1111; next q=1000.
  - At q=1001 counting up: j_dbg = k_dbg = 1001; next q=0000.
- Asynchronous reset mid-operation: assert reset=0 between clk edges while q=6.
  - Required: q=0 immediately, without waiting for an edge.
  - Hold with en=0 after release: q stays 0; j_dbg = k_dbg = 0000.
